// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential nibble-serial subtractor.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // 1 when the word holds an even number of set bits
    function automatic logic even_parity(input logic [DATA_W-1:0] v);
        return ~^v;
    endfunction

    // Two's-complement overflow of x - y from the operand and result sign bits
    function automatic logic signed_ovf(input logic xs, input logic ys, input logic zs);
        return (xs ^ ys) & (zs ^ xs);
    endfunction

endpackage

// File: rtl/nibble_sub.sv
// Combinational W-bit subtract slice: d = a - b - bin, with borrow-out.
module nibble_sub #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    logic [W:0] full_s;

    // The extra top bit of the widened difference is the borrow-out
    always_comb begin
        full_s = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        d      = full_s[W-1:0];
        bout   = full_s[W];
    end

endmodule

// File: rtl/sub16_seq.sv
// 16-bit subtractor that processes one nibble per cycle, LSB first, with a
// valid/ready handshake on both the operand and result sides.
module sub16_seq #(
    parameter int NIB_W = alu_pkg::NIB_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] z,
    output logic        sign,
    output logic        zero,
    output logic        borrow,
    output logic        parity,
    output logic        overflow
);

    import alu_pkg::*;

    localparam int NIB_CNT = DATA_W / NIB_W;
    localparam int IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;

    state_t              state_r;
    state_t              state_next_s;
    logic [DATA_W-1:0]   x_r;
    logic [DATA_W-1:0]   y_r;
    logic [DATA_W-1:0]   z_r;
    logic [IDX_W-1:0]    idx_r;
    logic                bin_r;
    logic                out_valid_r;
    logic                sign_r;
    logic                zero_r;
    logic                borrow_r;
    logic                parity_r;
    logic                overflow_r;

    logic [NIB_W-1:0]    a_s;
    logic [NIB_W-1:0]    b_s;
    logic [NIB_W-1:0]    d_s;
    logic                bout_s;
    logic                last_s;
    logic [DATA_W-1:0]   z_full_s;

    // Operand slice selection and the result word as it stands after this slice
    always_comb begin
        a_s      = x_r[int'(idx_r)*NIB_W +: NIB_W];
        b_s      = y_r[int'(idx_r)*NIB_W +: NIB_W];
        last_s   = (idx_r == IDX_W'(NIB_CNT - 1));
        z_full_s = {d_s, z_r[DATA_W-1:NIB_W]};
    end

    nibble_sub #(
        .W (NIB_W)
    ) u_nibble_sub (
        .a    (a_s),
        .b    (b_s),
        .bin  (bin_r),
        .d    (d_s),
        .bout (bout_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, nibble-serial accumulation and registered result flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_r         <= {DATA_W{1'b0}};
            y_r         <= {DATA_W{1'b0}};
            z_r         <= {DATA_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            bin_r       <= 1'b0;
            out_valid_r <= 1'b0;
            sign_r      <= 1'b0;
            zero_r      <= 1'b0;
            borrow_r    <= 1'b0;
            parity_r    <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        x_r   <= x;
                        y_r   <= y;
                        bin_r <= 1'b0;
                        idx_r <= {IDX_W{1'b0}};
                    end
                end
                CALC: begin
                    // Result is shifted in from the top so slice 0 ends up at bit 0
                    z_r   <= z_full_s;
                    bin_r <= bout_s;
                    idx_r <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        out_valid_r <= 1'b1;
                        sign_r      <= z_full_s[DATA_W-1];
                        zero_r      <= (z_full_s == {DATA_W{1'b0}});
                        borrow_r    <= bout_s;
                        parity_r    <= even_parity(z_full_s);
                        overflow_r  <= signed_ovf(x_r[DATA_W-1], y_r[DATA_W-1],
                                                  z_full_s[DATA_W-1]);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign z         = z_r;
    assign sign      = sign_r;
    assign zero      = zero_r;
    assign borrow    = borrow_r;
    assign parity    = parity_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_sub16_seq.sv
// Self-checking bench for sub16_seq: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_sub16_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z;
    logic        sign;
    logic        zero;
    logic        borrow;
    logic        parity;
    logic        overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit mon_en    = 1'b0;

    sub16_seq #(.NIB_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .sign      (sign),
        .zero      (zero),
        .borrow    (borrow),
        .parity    (parity),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {z, sign, zero, borrow, parity, overflow} from plain arithmetic
    function automatic logic [20:0] ref_res(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] d;
        int          sd;
        logic        ov;
        d  = a - b;
        sd = int'($signed(a)) - int'($signed(b));
        ov = (sd > 32767) || (sd < -32768);
        return {d, d[15], (d == 16'h0000), (a < b), (($countones(d) % 2) == 0), ov};
    endfunction

    function automatic logic [20:0] dut_res();
        return {z, sign, zero, borrow, parity, overflow};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom % 6)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, then present one operand pair for exactly one edge
    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("send_ready_timeout", 32'(n < 20), 32'd1);
        in_valid = 1'b1;
        x = a;
        y = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int cnt);
        cnt = start;
        while (!out_valid && cnt < 12) begin
            step();
            cnt++;
        end
    endtask

    // Transaction-level model: a result is due 4 edges after acceptance and
    // stays until handshaken; the block is busy from accept to handshake
    initial begin
        bit          m_busy;
        int          m_cnt;
        logic [20:0] m_exp;
        bit          exp_valid;
        m_busy = 1'b0;
        m_cnt  = 0;
        m_exp  = 21'h0;
        forever begin
            @(negedge clk);
            exp_valid = m_busy && (m_cnt >= 4);
            if (mon_en) begin
                chk("mon_in_ready", 32'(in_ready), 32'(!m_busy));
                chk("mon_out_valid", 32'(out_valid), 32'(exp_valid));
                if (exp_valid) begin
                    chk("mon_result", 32'(dut_res()), 32'(m_exp));
                end
            end
            if (!rst_n) begin
                m_busy = 1'b0;
                m_cnt  = 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_exp  = ref_res(x, y);
                end
            end else if (exp_valid && out_ready) begin
                m_busy = 1'b0;
            end else if (m_cnt < 4) begin
                m_cnt++;
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = 16'h0000;
        y         = 16'h0000;
        step();
        step();

        chk("reset_outputs", 32'({out_valid, dut_res()}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        step();

        chk("model_pin_5m3", 32'(ref_res(16'h0005, 16'h0003)), 32'({16'h0002, 5'b00000}));
        chk("model_pin_8000m1", 32'(ref_res(16'h8000, 16'h0001)), 32'({16'h7FFF, 5'b00001}));

        send(16'h0005, 16'h0003);
        wait_valid(0, cnt);
        chk("r032_latency", 32'(cnt), 32'd4);
        chk("r032_result", 32'(dut_res()), 32'({16'h0002, 5'b00000}));
        step();

        send(16'h0003, 16'h0005);
        wait_valid(0, cnt);
        chk("r033_result", 32'(dut_res()), 32'({16'hFFFE, 5'b10100}));
        step();

        send(16'h8000, 16'h0001);
        wait_valid(0, cnt);
        chk("r034_result", 32'(dut_res()), 32'({16'h7FFF, 5'b00001}));
        step();

        out_ready = 1'b0;
        send(16'h1234, 16'h1234);
        wait_valid(0, cnt);
        chk("r035_latency", 32'(cnt), 32'd4);
        for (int i = 0; i < 5; i++) begin
            chk("r035_hold_result", 32'(dut_res()), 32'({16'h0000, 5'b01010}));
            chk("r035_hold_valid", 32'(out_valid), 32'd1);
            chk("r035_hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("r035_released", 32'({out_valid, in_ready}), 32'b01);
        step();
        chk("r035_single_handshake", 32'(out_valid), 32'd0);

        send(16'h00F0, 16'h0F00);
        in_valid = 1'b1;
        x = 16'hFFFF;
        y = 16'h0001;
        step();
        in_valid = 1'b0;
        wait_valid(1, cnt);
        chk("r036_latency", 32'(cnt), 32'd4);
        chk("r036_result", 32'(dut_res()), 32'({16'hF1F0, 5'b10100}));
        step();

        send(16'hABCD, 16'h1111);
        step();
        rst_n = 1'b0;
        step();
        chk("r037_after_reset", 32'({out_valid, in_ready}), 32'b01);
        chk("r037_result_cleared", 32'(dut_res()), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("r037_no_stale", 32'(out_valid), 32'd0);
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            in_valid  = (($urandom % 3) == 0);
            x         = pick();
            y         = (($urandom % 8) == 0) ? x : pick();
            out_ready = (($urandom % 4) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
